ctrl_pipe_stage: RTL

Parametrised successor to the fixed per-stage control buffers between pipeline stages.
- Carries an opaque WIDTH-bit control bundle (type flags, rd/wr/rf enables, wb_sel, br_type, aluop, csr bits) from one stage to the next.
- Uses a valid/ready handshake with a 2-entry skid buffer, synchronous flush that injects a NOP bundle, and saturating stall/bubble counters.
- One instance sits at each stage boundary: IF/ID, ID/EX, EX/MEM, MEM/WB.

---
 rtl/ctrl_pipe_pkg.sv | 29 ++
 rtl/sat_counter.sv | 23 ++
 rtl/ctrl_pipe_stage.sv | 114 +++++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// Shared types and bundle layout for the inter-stage control buffers.
// The field offsets describe the current control bundle carried between stages.
package ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    localparam int CTRL_W = 32;
    localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

    localparam int TYPE_LSB    = 0;
    localparam int TYPE_W      = 6;
    localparam int RD_EN_BIT   = 6;
    localparam int WR_EN_BIT   = 7;
    localparam int WB_SEL_LSB  = 8;
    localparam int WB_SEL_W    = 2;
    localparam int RF_EN_BIT   = 10;
    localparam int BR_TYPE_LSB = 11;
    localparam int BR_TYPE_W   = 3;
    localparam int ALUOP_LSB   = 14;
    localparam int ALUOP_W     = 4;
    localparam int CSR_RD_BIT  = 18;
    localparam int CSR_WR_BIT  = 19;
    localparam int MRET_BIT    = 20;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Control bundle buffer between two pipeline stages.
// Two-entry skid buffer with flush-to-NOP and stall/bubble counters.
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(CTRL_NOP),
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             main_valid;
    logic             skid_valid;
    logic             acc;
    logic             drn;

    assign main_valid = (state_q != EMPTY);
    assign skid_valid = (state_q == TWO);
    assign acc        = in_valid & in_ready;
    assign drn        = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= NOP_WORD;
            skid_q  <= NOP_WORD;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (acc) state_d = ONE;
                ONE: begin
                    if (acc && !drn) state_d = TWO;
                    else if (!acc && drn) state_d = EMPTY;
                end
                TWO: if (drn) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Data path: main always feeds the output, skid only absorbs overflow.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d = NOP_WORD;
            skid_d = NOP_WORD;
        end else begin
            unique case (state_q)
                EMPTY: if (acc) main_d = in_data;
                ONE: begin
                    if (acc && drn) main_d = in_data;
                    if (acc && !drn) skid_d = in_data;
                end
                TWO: if (drn) main_d = skid_q;
                default: begin
                    main_d = NOP_WORD;
                    skid_d = NOP_WORD;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = !skid_valid;
        out_valid = main_valid;
        out_data  = main_valid ? main_q : NOP_WORD;
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (~out_valid & out_ready),
        .count (bubble_cnt)
    );

endmodule
